// File: rtl/or_sched_pkg.sv
// Shared definitions for the Or-cell scheduler: state encoding and the
// round-robin winner search.
package or_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned MAX_REQ = 64;
    localparam int unsigned IDX_W   = $clog2(MAX_REQ);

    // First set bit of req searching ptr+1, ptr+2, ... modulo n.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned     win;
        logic            found;
        logic [IDX_W-1:0] idx;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = IDX_W'((ptr + k) % n);
                if (!found && req[idx]) begin
                    win   = int'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/or_unit_scheduler_cell.sv
// Single-bit Or cell shared by all requesters of the scheduler.
module or_unit_scheduler_cell (
    input  logic a,
    input  logic b,
    output logic res
);
    assign res = a | b;
endmodule

// File: rtl/or_unit_scheduler.sv
// Round-robin scheduler that time-shares one 1-bit Or cell, running each
// granted operand pair through it bit-serially, LSB first.
module or_unit_scheduler
    import or_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned WIDTH   = 8,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_bus,
    input  logic [NUM_REQ*WIDTH-1:0] b_bus,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [WIDTH-1:0]         res,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_valid
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [WIDTH-1:0]   r_res;
    logic [ID_W-1:0]    r_res_id;
    logic               r_res_valid;

    logic [ID_W-1:0]    w_win;
    logic               w_cell_res;
    logic [WIDTH-1:0]   w_res_next;

    assign w_win = ID_W'(rr_pick(MAX_REQ'(req), 32'(r_ptr), NUM_REQ));

    or_unit_scheduler_cell u_cell (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .res (w_cell_res)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_res_next = w_cell_res;
        end else begin : g_wn
            assign w_res_next = {w_cell_res, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_res       <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_a_sh  <= a_bus[w_win*WIDTH +: WIDTH];
                        r_b_sh  <= b_bus[w_win*WIDTH +: WIDTH];
                        r_id    <= w_win;
                        r_ptr   <= w_win;
                        r_cnt   <= '0;
                        r_gnt   <= NUM_REQ'(1) << w_win;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res_sh <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state     <= DONE;
                        r_res       <= w_res_next;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != IDLE);
    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;

endmodule

// File: tb/tb_or_unit_scheduler.sv
// Scoreboard bench for or_unit_scheduler: an 8-bit, 4-requester build and a
// 1-bit build sharing clock and reset.
module tb_or_unit_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  res;
    logic [1:0]  res_id;
    logic        res_valid;

    logic [3:0]  req1 = '0;
    logic [3:0]  a1_bus = '0;
    logic [3:0]  b1_bus = '0;
    logic [3:0]  gnt1;
    logic        busy1;
    logic [0:0]  res1;
    logic [1:0]  res_id1;
    logic        res_valid1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_ptr  = 3;
    logic [9:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    or_unit_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .busy(busy), .res(res), .res_id(res_id), .res_valid(res_valid)
    );

    or_unit_scheduler #(.NUM_REQ(4), .WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .a_bus(a1_bus), .b_bus(b1_bus),
        .gnt(gnt1), .busy(busy1), .res(res1), .res_id(res_id1), .res_valid(res_valid1)
    );

    // Every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d res=%h, none expected", res_id, res);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                if ({res_id, res} !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got id=%0d res=%h, expected id=%0d res=%h",
                             res_id, res, e[9:8], e[7:0]);
                end
            end
        end
    end

    function automatic int pick(input logic [3:0] r, input int p);
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++)
            if (w < 0 && r[(p + k) % 4]) w = (p + k) % 4;
        return w;
    endfunction

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt != 0) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (res_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (gnt !== 4'b0)     begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (res !== 8'h0)     begin n_fail++; $display("FAIL rst_res: got %h want 00", res); end
        if (res_id !== 2'd0)  begin n_fail++; $display("FAIL rst_res_id: got %0d want 0", res_id); end
        if (res_valid !== 0)  begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        rst = 1'b0;
        exp_ptr = 3;
    endtask

    task automatic test_single;
        logic ok; logic bad; int n;
        req = 4'b0001; a_bus[7:0] = 8'hA5; b_bus[7:0] = 8'h0F;
        sb.push_back({2'd0, 8'hAF});
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_gnt: got %b want 1", busy); end
        exp_ptr = 0;
        req = '0;
        bad = 1'b0; n = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1 || gnt !== 4'b0) bad = 1'b1;
            if (res_valid) ok = 1'b1;
        end
        n_checks++;
        if (!ok || n != 8) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 8", n); end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL single_busy_run: busy dropped or gnt repeated, want busy=1 gnt=0"); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_fair;
        logic ok; int n; int prev; int w;
        for (int i = 0; i < 4; i++) begin
            a_bus[i*8 +: 8] = 8'(i);
            b_bus[i*8 +: 8] = 8'h10;
        end
        req  = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            w = pick(4'b1111, exp_ptr);
            sb.push_back({2'(w), 8'(w) | 8'h10});
            wait_gnt(ok);
            n_checks++;
            if (!ok || gnt !== 4'(1 << w)) begin n_fail++; $display("FAIL fair_gnt%0d: got %b want %b", k, gnt, 4'(1 << w)); end
            exp_ptr = w;
            if (k == 4) req = '0;
            wait_valid(n, ok);
            n_checks++;
            if (!ok || n != 8) begin n_fail++; $display("FAIL fair_latency%0d: got %0d want 8", k, n); end
            if (prev >= 0) begin
                n_checks++;
                if (cyc - prev != 10) begin n_fail++; $display("FAIL fair_spacing%0d: got %0d want 10", k, cyc - prev); end
            end
            prev = cyc;
        end
    endtask

    task automatic test_ptr;
        logic ok; int n;
        a_bus = 32'h33_22_11_00; b_bus = 32'h03_40_08_80;
        req = 4'b0100;
        sb.push_back({2'd2, 8'h62});
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0100) begin n_fail++; $display("FAIL ptr_gnt2: got %b want 0100", gnt); end
        req = '0;
        wait_valid(n, ok);
        req = 4'b1010;
        sb.push_back({2'd3, 8'h33});
        sb.push_back({2'd1, 8'h19});
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b1000) begin n_fail++; $display("FAIL ptr_gnt3_first: got %b want 1000", gnt); end
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0010) begin n_fail++; $display("FAIL ptr_gnt1_second: got %b want 0010", gnt); end
        req = '0;
        exp_ptr = 1;
        wait_valid(n, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ptr_done: no res_valid within bound, want one"); end
    endtask

    task automatic test_capture;
        logic ok; int n;
        req = 4'b0010; a_bus[15:8] = 8'h3C; b_bus[15:8] = 8'h41;
        sb.push_back({2'd1, 8'h7D});
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0010) begin n_fail++; $display("FAIL cap_gnt: got %b want 0010", gnt); end
        req = '0;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            a_bus[15:8] = 8'($urandom);
            b_bus[15:8] = 8'($urandom);
            @(negedge clk);
            n++;
            if (res_valid) ok = 1'b1;
        end
        n_checks++;
        if (!ok || n != 8) begin n_fail++; $display("FAIL cap_latency: got %0d want 8", n); end
        exp_ptr = 1;
    endtask

    task automatic test_reset_mid;
        logic ok; logic bad; int n;
        req = 4'b0100; a_bus[23:16] = 8'hF0; b_bus[23:16] = 8'h01;
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0100) begin n_fail++; $display("FAIL rmid_gnt: got %b want 0100", gnt); end
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (res !== 8'h0)    begin n_fail++; $display("FAIL rmid_res: got %h want 00", res); end
        if (res_id !== 2'd0) begin n_fail++; $display("FAIL rmid_res_id: got %0d want 0", res_id); end
        if (res_valid !== 0 || gnt !== 4'b0) begin n_fail++; $display("FAIL rmid_strobes: got rv=%b gnt=%b want 0", res_valid, gnt); end
        rst = 1'b0;
        exp_ptr = 3;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL rmid_abort: activity after reset, want none"); end
        req = 4'b1111; a_bus[7:0] = 8'h81; b_bus[7:0] = 8'h18;
        sb.push_back({2'd0, 8'h99});
        wait_gnt(ok);
        n_checks++;
        if (!ok || gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_pri: got %b want 0001", gnt); end
        req = '0;
        exp_ptr = 0;
        wait_valid(n, ok);
        n_checks++;
        if (!ok || n != 8) begin n_fail++; $display("FAIL rmid_latency: got %0d want 8", n); end
    endtask

    task automatic test_width1;
        logic ok; logic a; logic b;
        for (int k = 0; k < 4; k++) begin
            a = k[1]; b = k[0];
            req1 = 4'b0001; a1_bus[0] = a; b1_bus[0] = b;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (gnt1 != 0) ok = 1'b1;
            end
            n_checks++;
            if (!ok || gnt1 !== 4'b0001) begin n_fail++; $display("FAIL w1_gnt%0d: got %b want 0001", k, gnt1); end
            req1 = '0;
            @(negedge clk);
            n_checks += 2;
            if (res_valid1 !== 1'b1) begin n_fail++; $display("FAIL w1_valid%0d: got %b want 1", k, res_valid1); end
            if (res1 !== (a | b) || res_id1 !== 2'd0) begin
                n_fail++; $display("FAIL w1_res%0d: got res=%b id=%0d want res=%b id=0", k, res1, res_id1, a | b);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fair;
        test_ptr;
        test_capture;
        test_reset_mid;
        test_width1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
